branch_predict_gen: RTL and testbench
=====================================

BRANCH_PREDICT_GEN -- requirements
Module: branch_predict_gen

Interface
REQ-001 SHALL have parameter PC_W, default 8: instruction address width.
REQ-002 SHALL have parameter LANES, default 2, power of 2 from 2 to 8: fetch/issue lanes per fetch group.
REQ-003 SHALL have parameter BHT_DEPTH, default 16, power of 2: number of prediction counters.
REQ-004 Port clk, input, 1: the only clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port fetch_next_in, input, 1: the pipeline advances this cycle; 0 means stall.
REQ-007 Port pc, input, PC_W: current fetch-group base address, LANES-aligned.
REQ-008 Port ir_in, input, 16*LANES: lane i instruction is ir_in[16i+15:16i].
REQ-009 Port do_delayed_b, input, LANES: lane i is re-issuing a delayed branch (destination format).
REQ-010 Port resolve_valid, input, 1: a conditional branch resolved in stage 3.
REQ-011 Port resolve_pc, input, PC_W: address of the resolved branch.
REQ-012 Port resolve_taken, input, 1: actual outcome of the resolved branch.
REQ-013 Port pc_next_out, output, PC_W: next fetch base, LANES-aligned.
REQ-014 Port lane_invalid_out, output, LANES: squash lane i of the current group.
REQ-015 Port br_lane_out, output, LANES: one-hot lane of the winning branch, or zero.
REQ-016 Port delayed_dest_out, output, PC_W*LANES: per-lane delayed destination.
REQ-017 Port delayed_cond_out, output, 3*LANES: per-lane delayed condition (NV=0, AL=1, EQ=2, NE=3, LT=4, LE=5, GT=6, GE=7).
REQ-018 Port delayed_head_out, output, 8*LANES: per-lane delayed instruction head.
REQ-019 Port reset_s1, output, 1: squash stage 1.
REQ-020 Port halted, output, 1: the core is halted.
REQ-021 Port halt_addr, output, PC_W: PC+1 of the HALT instruction.

Function
REQ-022 Lane i address SHALL be pc+i; its PC+1 SHALL be pc+i+1 mod 2^PC_W.
REQ-023 A lane SHALL be a branch when ir[15:13] is 001, 010 or 111, it is not squashed, and reset_s1=0.
  - The lowest-index branch lane wins; higher lanes see no effect.
REQ-024 Branch decode per lane SHALL follow these rules.
  - Unconditional branch: now = PC+1+imm8 (AL); delayed = PC+1 with cond NV.
  - BEQ/BNE/BLT/BLE: the two paths carry complementary conditions; the predicted path is "now" and the other is delayed.
  - BL: branch now, delayed NV.
  - BX/BLX: now = PC+1; delayed cond AL.
  - HALT (111): now = PC+1 with cond NV; delayed = PC+1, cond AL, head 8'b00100111.
  - When do_delayed_b[i]=1, imm8 is an absolute destination.
REQ-025 Conditional prediction SHALL use counter index = lane address[log2(BHT_DEPTH)-1:0]; predict taken when counter[1]=1.
REQ-026 On resolve_valid the indexed 2-bit counter SHALL increment (taken) or decrement (not taken), saturating at 3 and 0.
  - A same-cycle lookup of that index reads the pre-update value.
REQ-027 pc_next_out SHALL be the winning "now" destination with its low log2(LANES) bits cleared; with no winning branch it is pc+LANES, wrapping.
REQ-028 On fetch_next_in=1 the block SHALL record destination[log2(LANES)-1:0] and apply it two fetches later.
  - Lanes below that offset are asserted in lane_invalid_out.
  - A lane with do_delayed_b=1 is never squashed.
REQ-029 Branch-squash register behaviour:
  - On fetch_next_in=1 it loads "any winning branch", except it loads 0 when any delayed_cond_out is AL.
  - reset_s1 = register & fetch_next_in & ~|do_delayed_b.
REQ-030 Non-branch or squashed lanes SHALL drive delayed_cond_out NV.
REQ-031 Halt FSM, states RUN and HALTED:
  - RUN to HALTED when a do_delayed_b lane holds 001_00_111 and the branch-squash register is 0.
  - halt_addr captures that lane's imm, lowest lane winning.
  - HALTED is sticky until rst; while in it pc_next_out = pc and br_lane_out = 0.
REQ-032 With fetch_next_in=0, all registers SHALL hold and outputs remain combinational.

Reset
REQ-033 rst SHALL set the halt FSM to RUN, halted=0, halt_addr=0, the branch-squash register to 1, pending offsets to 0, and all counters to 01 (weakly not taken).

Structure
REQ-034 Condition codes, opcode constants and the HALT head SHALL live in the shared package bgu_pkg.
REQ-035 Per-lane decode SHALL be sub-module lane_branch_decode, instantiated LANES times; the counter table stays in the top module.

Verification
REQ-036 Bench SHALL cover at least the following directed scenarios.
  - LANES=2, pc=0x04, lane0 = unconditional B imm=0x0C -> pc_next_out=0x10; two fetches later lane_invalid_out=01 (target 0x11).
  - Counter for index 3 at reset; lane1 BEQ at 0x03 -> now 0x04, delayed EQ; after 2 resolve_taken at 0x03, same branch -> now target, delayed NE.
  - 5 resolve_taken at one index -> counter saturates at 3; 1 not-taken -> predicts taken.
  - Branch in lane0 and lane1 -> br_lane_out=01.
  - Delayed HALT head on lane1, imm=0x21 -> halted=1, halt_addr=0x21, pc_next_out frozen until rst.
  - rst asserted mid-stall -> immediate reset values regardless of clk.

Source files
------------

// File: rtl/bgu_pkg.sv
// Shared branch-generation definitions: condition codes, opcode fields,
// the delayed HALT head and condition helpers.
package bgu_pkg;

    typedef enum logic [2:0] {
        C_NV = 3'd0,
        C_AL = 3'd1,
        C_EQ = 3'd2,
        C_NE = 3'd3,
        C_LT = 3'd4,
        C_LE = 3'd5,
        C_GT = 3'd6,
        C_GE = 3'd7
    } cond_e;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } halt_e;

    localparam logic [2:0] OP_B    = 3'b001;
    localparam logic [2:0] OP_BC   = 3'b010;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [2:0] K_BX  = 3'b010;
    localparam logic [2:0] K_BLX = 3'b011;

    localparam logic [7:0] HALT_HEAD = 8'b0010_0111;

    // ir[12:11]: 00 BEQ, 01 BNE, 10 BLT, 11 BLE
    function automatic cond_e cond_of(input logic [1:0] f);
        return cond_e'(3'd2 + {1'b0, f});
    endfunction

    function automatic cond_e cond_inv(input cond_e c);
        case (c)
            C_EQ:    return C_NE;
            C_NE:    return C_EQ;
            C_LT:    return C_GE;
            C_GE:    return C_LT;
            C_LE:    return C_GT;
            C_GT:    return C_LE;
            C_AL:    return C_NV;
            default: return C_AL;
        endcase
    endfunction

endpackage

// File: rtl/lane_branch_decode.sv
// Single-lane branch decode: splits a branch into the path taken now
// and the path re-issued later in destination format.
module lane_branch_decode
    import bgu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] lane_pc,
    input  logic [15:0]     ir,
    input  logic            delayed,
    input  logic            pred_taken,
    output logic            br_op,
    output logic [PC_W-1:0] now_dest,
    output logic [PC_W-1:0] d_dest,
    output logic [2:0]      d_cond,
    output logic [7:0]      d_head,
    output logic            halt_mark
);

    logic [PC_W-1:0] p1;
    logic [PC_W-1:0] tgt;
    logic            is_b;
    logic            is_c;
    logic            is_h;
    logic            is_rx;
    logic            is_jmp;
    cond_e           c;

    assign p1  = lane_pc + PC_W'(1);
    assign tgt = delayed ? PC_W'(ir[7:0]) : p1 + PC_W'(ir[7:0]);

    assign is_b   = (ir[15:13] == OP_B);
    assign is_c   = (ir[15:13] == OP_BC);
    assign is_h   = (ir[15:13] == OP_HALT);
    assign is_rx  = is_b & ((ir[10:8] == K_BX) | (ir[10:8] == K_BLX));
    assign is_jmp = is_b & ~is_rx;
    assign c      = cond_of(ir[12:11]);

    assign br_op     = is_b | is_c | is_h;
    assign halt_mark = delayed & (ir[15:8] == HALT_HEAD);

    always_comb begin
        now_dest = p1;
        d_dest   = p1;
        d_cond   = C_NV;
        d_head   = ir[15:8];
        unique case (1'b1)
            is_h: begin
                d_cond = C_AL;
                d_head = HALT_HEAD;
            end
            is_c: begin
                if (pred_taken) begin
                    now_dest = tgt;
                    d_cond   = cond_inv(c);
                end else begin
                    d_dest = tgt;
                    d_cond = c;
                end
            end
            is_rx: begin
                d_dest = tgt;
                d_cond = C_AL;
            end
            is_jmp: begin
                now_dest = tgt;
            end
            default: begin
                d_cond = C_NV;
            end
        endcase
    end

endmodule

// File: rtl/branch_predict_gen.sv
// Fetch-group branch selection with 2-bit counter prediction, delayed
// path generation, two-fetch lane squash and a sticky halt state.
module branch_predict_gen
    import bgu_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int LANES     = 2,
    parameter int BHT_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_next_in,
    input  logic [PC_W-1:0]       pc,
    input  logic [16*LANES-1:0]   ir_in,
    input  logic [LANES-1:0]      do_delayed_b,
    input  logic                  resolve_valid,
    input  logic [PC_W-1:0]       resolve_pc,
    input  logic                  resolve_taken,
    output logic [PC_W-1:0]       pc_next_out,
    output logic [LANES-1:0]      lane_invalid_out,
    output logic [LANES-1:0]      br_lane_out,
    output logic [PC_W*LANES-1:0] delayed_dest_out,
    output logic [3*LANES-1:0]    delayed_cond_out,
    output logic [8*LANES-1:0]    delayed_head_out,
    output logic                  reset_s1,
    output logic                  halted,
    output logic [PC_W-1:0]       halt_addr
);

    localparam int LW = $clog2(LANES);
    localparam int IW = $clog2(BHT_DEPTH);

    logic [1:0]      cnt [BHT_DEPTH];
    logic [PC_W-1:0] lane_pc [LANES];
    logic [PC_W-1:0] now_dest [LANES];
    logic [PC_W-1:0] d_dest [LANES];
    logic [2:0]      d_cond [LANES];
    logic [7:0]      d_head [LANES];
    logic [LANES-1:0] br_op;
    logic [LANES-1:0] hmark;
    logic [LANES-1:0] is_br;

    logic [LANES-1:0] win_oh;
    logic [PC_W-1:0]  win_dest;
    logic             any_win;
    logic             any_al;
    logic             hm_any;
    logic [PC_W-1:0]  hm_imm;

    logic [LW-1:0] off1;
    logic [LW-1:0] off2;
    logic          sq;
    halt_e         state;
    halt_e         state_nx;

    logic [IW-1:0] ridx;
    logic [1:0]    rcur;
    logic [1:0]    rnxt;
    logic          unused_rpc;

    assign unused_rpc = ^resolve_pc;
    assign reset_s1   = sq & fetch_next_in & ~|do_delayed_b;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic pred;

        assign lane_pc[i] = pc + PC_W'(i);
        assign pred       = cnt[lane_pc[i][IW-1:0]][1];

        lane_branch_decode #(
            .PC_W(PC_W)
        ) u_dec (
            .lane_pc   (lane_pc[i]),
            .ir        (ir_in[16*i +: 16]),
            .delayed   (do_delayed_b[i]),
            .pred_taken(pred),
            .br_op     (br_op[i]),
            .now_dest  (now_dest[i]),
            .d_dest    (d_dest[i]),
            .d_cond    (d_cond[i]),
            .d_head    (d_head[i]),
            .halt_mark (hmark[i])
        );

        // squash from the offset recorded two fetches ago
        assign lane_invalid_out[i] = (off2 > LW'(i)) & ~do_delayed_b[i];
        assign is_br[i] = br_op[i] & ~lane_invalid_out[i] & ~reset_s1;

        assign delayed_dest_out[PC_W*i +: PC_W] = d_dest[i];
        assign delayed_cond_out[3*i +: 3] = is_br[i] ? d_cond[i] : C_NV;
        assign delayed_head_out[8*i +: 8] = d_head[i];
    end

    always_comb begin
        win_oh   = '0;
        win_dest = pc + PC_W'(LANES);
        any_win  = 1'b0;
        any_al   = 1'b0;
        hm_any   = 1'b0;
        hm_imm   = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (is_br[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_dest  = now_dest[i];
                any_win   = 1'b1;
                if (d_cond[i] == C_AL) any_al = 1'b1;
            end
            if (hmark[i]) begin
                hm_any = 1'b1;
                hm_imm = PC_W'(ir_in[16*i +: 8]);
            end
        end
    end

    always_comb begin
        if (halted) pc_next_out = pc;
        else if (any_win) pc_next_out = {win_dest[PC_W-1:LW], {LW{1'b0}}};
        else pc_next_out = win_dest;
    end

    assign br_lane_out = halted ? '0 : win_oh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq   <= 1'b1;
            off1 <= '0;
            off2 <= '0;
        end else if (fetch_next_in) begin
            sq   <= any_win & ~any_al;
            off1 <= any_win ? win_dest[LW-1:0] : '0;
            off2 <= off1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RUN;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == S_RUN && fetch_next_in && hm_any && !sq)
            state_nx = S_HALTED;
    end

    always_comb begin
        halted = (state == S_HALTED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            halt_addr <= '0;
        else if (state == S_RUN && state_nx == S_HALTED)
            halt_addr <= hm_imm;
    end

    assign ridx = resolve_pc[IW-1:0];
    assign rcur = cnt[ridx];

    always_comb begin
        if (resolve_taken) rnxt = (rcur == 2'd3) ? rcur : rcur + 2'd1;
        else               rnxt = (rcur == 2'd0) ? rcur : rcur - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < BHT_DEPTH; j++) cnt[j] <= 2'b01;
        end else if (fetch_next_in && resolve_valid) begin
            cnt[ridx] <= rnxt;
        end
    end

endmodule

// File: tb/tb_branch_predict_gen.sv
// Directed-vector bench for branch_predict_gen with LANES=2, PC_W=8,
// BHT_DEPTH=16.
module tb_branch_predict_gen;

    logic        clk;
    logic        rst;
    logic        fetch_next_in;
    logic [7:0]  pc;
    logic [31:0] ir_in;
    logic [1:0]  do_delayed_b;
    logic        resolve_valid;
    logic [7:0]  resolve_pc;
    logic        resolve_taken;
    logic [7:0]  pc_next_out;
    logic [1:0]  lane_invalid_out;
    logic [1:0]  br_lane_out;
    logic [15:0] delayed_dest_out;
    logic [5:0]  delayed_cond_out;
    logic [15:0] delayed_head_out;
    logic        reset_s1;
    logic        halted;
    logic [7:0]  halt_addr;

    int checks = 0;
    int errors = 0;

    branch_predict_gen #(
        .PC_W(8),
        .LANES(2),
        .BHT_DEPTH(16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_next_in   (fetch_next_in),
        .pc              (pc),
        .ir_in           (ir_in),
        .do_delayed_b    (do_delayed_b),
        .resolve_valid   (resolve_valid),
        .resolve_pc      (resolve_pc),
        .resolve_taken   (resolve_taken),
        .pc_next_out     (pc_next_out),
        .lane_invalid_out(lane_invalid_out),
        .br_lane_out     (br_lane_out),
        .delayed_dest_out(delayed_dest_out),
        .delayed_cond_out(delayed_cond_out),
        .delayed_head_out(delayed_head_out),
        .reset_s1        (reset_s1),
        .halted          (halted),
        .halt_addr       (halt_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fetch_next_in = 1'b1;
        pc = 8'h04;
        ir_in = 32'h0;
        do_delayed_b = 2'b00;
        resolve_valid = 1'b0;
        resolve_pc = 8'h00;
        resolve_taken = 1'b0;
        #2;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
        checks++; if (halt_addr !== 8'h00) begin errors++; $display("FAIL rst_haddr got %h want 00", halt_addr); end
        checks++; if (reset_s1 !== 1'b1) begin errors++; $display("FAIL rst_s1 got %b want 1", reset_s1); end
        checks++; if (lane_invalid_out !== 2'b00) begin errors++; $display("FAIL rst_inv got %b want 00", lane_invalid_out); end
        checks++; if (pc_next_out !== 8'h06) begin errors++; $display("FAIL rst_pcn got %h want 06", pc_next_out); end
        step();
        step();
        rst = 1'b0;
        step();
        checks++; if (reset_s1 !== 1'b0) begin errors++; $display("FAIL warm_s1 got %b want 0", reset_s1); end
    endtask

    task automatic test_uncond();
        pc = 8'h04;
        ir_in = {16'h0000, 16'h200C};
        #1;
        checks++; if (pc_next_out !== 8'h10) begin errors++; $display("FAIL b_pcn got %h want 10", pc_next_out); end
        checks++; if (br_lane_out !== 2'b01) begin errors++; $display("FAIL b_lane got %b want 01", br_lane_out); end
        checks++; if (delayed_cond_out[2:0] !== 3'd0) begin errors++; $display("FAIL b_dcond got %0d want 0", delayed_cond_out[2:0]); end
        checks++; if (delayed_dest_out[7:0] !== 8'h05) begin errors++; $display("FAIL b_ddest got %h want 05", delayed_dest_out[7:0]); end
        checks++; if (delayed_head_out[7:0] !== 8'h20) begin errors++; $display("FAIL b_dhead got %h want 20", delayed_head_out[7:0]); end
        step();
        pc = 8'h06;
        ir_in = 32'h0;
        #1;
        checks++; if (reset_s1 !== 1'b1) begin errors++; $display("FAIL b_slot_s1 got %b want 1", reset_s1); end
        checks++; if (lane_invalid_out !== 2'b00) begin errors++; $display("FAIL b_inv1 got %b want 00", lane_invalid_out); end
        step();
        pc = 8'h10;
        #1;
        checks++; if (lane_invalid_out !== 2'b01) begin errors++; $display("FAIL b_inv2 got %b want 01", lane_invalid_out); end
        ir_in = {16'h2004, 16'h2000};
        #1;
        checks++; if (br_lane_out !== 2'b10) begin errors++; $display("FAIL sq_lane got %b want 10", br_lane_out); end
        checks++; if (pc_next_out !== 8'h16) begin errors++; $display("FAIL sq_pcn got %h want 16", pc_next_out); end
        do_delayed_b = 2'b01;
        #1;
        checks++; if (lane_invalid_out !== 2'b00) begin errors++; $display("FAIL dly_inv got %b want 00", lane_invalid_out); end
        ir_in = 32'h0;
        do_delayed_b = 2'b00;
        step();
    endtask

    task automatic test_predict();
        pc = 8'h02;
        ir_in = {16'h4010, 16'h0000};
        #1;
        checks++; if (pc_next_out !== 8'h04) begin errors++; $display("FAIL p_nt_pcn got %h want 04", pc_next_out); end
        checks++; if (br_lane_out !== 2'b10) begin errors++; $display("FAIL p_lane got %b want 10", br_lane_out); end
        checks++; if (delayed_cond_out[5:3] !== 3'd2) begin errors++; $display("FAIL p_nt_cond got %0d want 2", delayed_cond_out[5:3]); end
        checks++; if (delayed_dest_out[15:8] !== 8'h14) begin errors++; $display("FAIL p_nt_dest got %h want 14", delayed_dest_out[15:8]); end
        checks++; if (delayed_cond_out[2:0] !== 3'd0) begin errors++; $display("FAIL p_nop_cond got %0d want 0", delayed_cond_out[2:0]); end
        ir_in = 32'h0;
        resolve_valid = 1'b1;
        resolve_pc = 8'h03;
        resolve_taken = 1'b1;
        step();
        step();
        resolve_valid = 1'b0;
        ir_in = {16'h4010, 16'h0000};
        #1;
        checks++; if (pc_next_out !== 8'h14) begin errors++; $display("FAIL p_t_pcn got %h want 14", pc_next_out); end
        checks++; if (delayed_cond_out[5:3] !== 3'd3) begin errors++; $display("FAIL p_t_cond got %0d want 3", delayed_cond_out[5:3]); end
        checks++; if (delayed_dest_out[15:8] !== 8'h04) begin errors++; $display("FAIL p_t_dest got %h want 04", delayed_dest_out[15:8]); end
        ir_in = 32'h0;
    endtask

    task automatic test_saturate();
        resolve_valid = 1'b1;
        resolve_pc = 8'h05;
        resolve_taken = 1'b1;
        for (int k = 0; k < 5; k++) step();
        resolve_taken = 1'b0;
        pc = 8'h04;
        ir_in = {16'h4002, 16'h0000};
        #1;
        checks++; if (pc_next_out !== 8'h08) begin errors++; $display("FAIL s_pre_pcn got %h want 08", pc_next_out); end
        checks++; if (delayed_cond_out[5:3] !== 3'd3) begin errors++; $display("FAIL s_pre_cond got %0d want 3", delayed_cond_out[5:3]); end
        ir_in = 32'h0;
        step();
        resolve_valid = 1'b0;
        ir_in = {16'h4002, 16'h0000};
        #1;
        checks++; if (pc_next_out !== 8'h08) begin errors++; $display("FAIL s_sat_pcn got %h want 08", pc_next_out); end
        ir_in = 32'h0;
        resolve_valid = 1'b1;
        step();
        resolve_valid = 1'b0;
        ir_in = {16'h4002, 16'h0000};
        #1;
        checks++; if (pc_next_out !== 8'h06) begin errors++; $display("FAIL s_wnt_pcn got %h want 06", pc_next_out); end
        checks++; if (delayed_cond_out[5:3] !== 3'd2) begin errors++; $display("FAIL s_wnt_cond got %0d want 2", delayed_cond_out[5:3]); end
        ir_in = 32'h0;
    endtask

    task automatic test_back_to_back();
        pc = 8'h08;
        ir_in = {16'h2020, 16'h2002};
        #1;
        checks++; if (br_lane_out !== 2'b01) begin errors++; $display("FAIL two_lane got %b want 01", br_lane_out); end
        checks++; if (pc_next_out !== 8'h0A) begin errors++; $display("FAIL two_pcn got %h want 0a", pc_next_out); end
        step();
        fetch_next_in = 1'b0;
        ir_in = 32'h0;
        #1;
        checks++; if (reset_s1 !== 1'b0) begin errors++; $display("FAIL stall_s1 got %b want 0", reset_s1); end
        for (int k = 0; k < 3; k++) step();
        checks++; if (lane_invalid_out !== 2'b00) begin errors++; $display("FAIL stall_inv got %b want 00", lane_invalid_out); end
        fetch_next_in = 1'b1;
        #1;
        checks++; if (reset_s1 !== 1'b1) begin errors++; $display("FAIL stall_hold_s1 got %b want 1", reset_s1); end
        step();
        checks++; if (lane_invalid_out !== 2'b01) begin errors++; $display("FAIL resume_inv got %b want 01", lane_invalid_out); end
        step();
        checks++; if (lane_invalid_out !== 2'b00) begin errors++; $display("FAIL clear_inv got %b want 00", lane_invalid_out); end
    endtask

    task automatic test_halt();
        pc = 8'h0A;
        ir_in = {16'h2721, 16'h0000};
        do_delayed_b = 2'b10;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL h_pre got %b want 0", halted); end
        checks++; if (pc_next_out !== 8'h20) begin errors++; $display("FAIL h_pre_pcn got %h want 20", pc_next_out); end
        step();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL h_halted got %b want 1", halted); end
        checks++; if (halt_addr !== 8'h21) begin errors++; $display("FAIL h_addr got %h want 21", halt_addr); end
        do_delayed_b = 2'b00;
        pc = 8'h30;
        ir_in = {16'h0000, 16'h2005};
        #1;
        checks++; if (pc_next_out !== 8'h30) begin errors++; $display("FAIL h_pcn got %h want 30", pc_next_out); end
        checks++; if (br_lane_out !== 2'b00) begin errors++; $display("FAIL h_lane got %b want 00", br_lane_out); end
        for (int k = 0; k < 3; k++) step();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL h_sticky got %b want 1", halted); end
        checks++; if (pc_next_out !== 8'h30) begin errors++; $display("FAIL h_sticky_pcn got %h want 30", pc_next_out); end
    endtask

    task automatic test_rst_stall();
        fetch_next_in = 1'b0;
        ir_in = 32'h0;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL ar_halted got %b want 0", halted); end
        checks++; if (halt_addr !== 8'h00) begin errors++; $display("FAIL ar_haddr got %h want 00", halt_addr); end
        checks++; if (pc_next_out !== 8'h32) begin errors++; $display("FAIL ar_pcn got %h want 32", pc_next_out); end
        step();
        fetch_next_in = 1'b1;
        #1;
        checks++; if (reset_s1 !== 1'b1) begin errors++; $display("FAIL ar_s1 got %b want 1", reset_s1); end
        rst = 1'b0;
        step();
        pc = 8'h02;
        ir_in = {16'h4010, 16'h0000};
        #1;
        checks++; if (pc_next_out !== 8'h04) begin errors++; $display("FAIL ar_cnt_pcn got %h want 04", pc_next_out); end
        checks++; if (delayed_cond_out[5:3] !== 3'd2) begin errors++; $display("FAIL ar_cnt_cond got %0d want 2", delayed_cond_out[5:3]); end
        ir_in = 32'h0;
    endtask

    initial begin
        test_reset();
        test_uncond();
        test_predict();
        test_saturate();
        test_back_to_back();
        test_halt();
        test_rst_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
